// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the PC, issues
// word requests to instruction memory over a level req / ready handshake, and
// presents instruction, PC and PC+4 to the IF/ID register (which samples on
// the falling edge). Honours the hazard-unit stall and redirects on a taken
// branch/jump from EX. Any in-flight memory access is allowed to finish before
// a redirected fetch is issued.
//
// Ports:
//   clk             in   clock, all state updates on posedge
//   rst             in   synchronous active-high reset
//   stall           in   hazard stall: hold PC and outputs
//   next_pc_src     in   redirect request (taken branch/jump)
//   branch_target   in   redirect PC (low two bits ignored)
//   imem_req        out  memory request, level
//   imem_addr       out  word address of the request
//   imem_rdata      in   instruction data, valid while imem_ready=1
//   imem_ready      in   request completes this cycle
//   instruction_out out  fetched instruction, 0 when not valid
//   pc_out          out  PC of instruction_out
//   sum_out         out  pc_out + 4
//   fetch_valid     out  outputs carry a real instruction
//
// States:
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_FETCH | request at pc is outstanding; deliver on ready
//   S_HOLD  | response captured in skid while stalled; no request issued
//   S_DRAIN | redirected while a request was pending; finish it, drop data
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                XLEN     = 32,  // only 32 is supported
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            next_pc_src,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] instruction_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] sum_out,
  output logic            fetch_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] drain_addr;

  // Redirect targets are forced onto a word boundary; the dropped bits are
  // intentionally unused.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = &{1'b0, branch_target[1:0]};

  // Modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = {branch_target[XLEN-1:2], 2'b00};

  // Request lines decode straight from registered state so they never glitch
  // on input changes. In DRAIN the address is the latched one, keeping it
  // stable until the pending access completes even though pc has moved on.
  assign imem_req  = (state != S_HOLD);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_FETCH;
      pc              <= RESET_PC;
      instruction_out <= '0;
      pc_out          <= '0;
      sum_out         <= '0;
      fetch_valid     <= 1'b0;
      skid_instr      <= '0;
      skid_pc         <= '0;
      drain_addr      <= '0;
    end else if (next_pc_src) begin
      // Redirect beats stall in every state; whatever was fetched on the old
      // path is squashed.
      pc              <= redirect_pc;
      instruction_out <= '0;
      pc_out          <= '0;
      sum_out         <= '0;
      fetch_valid     <= 1'b0;
      skid_instr      <= '0;
      skid_pc         <= '0;
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_FETCH;
          end else begin
            // The memory still owes us a response for pc; it must not be
            // withdrawn, so wait it out at the old address.
            drain_addr <= pc;
            state      <= S_DRAIN;
          end
        end
        S_HOLD: begin
          state <= S_FETCH;
        end
        S_DRAIN: begin
          // Newest target already written to pc; drain_addr is untouched.
          state <= imem_ready ? S_FETCH : S_DRAIN;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              // IF/ID is frozen but the memory has already answered; park
              // the response so it is neither lost nor refetched.
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= S_HOLD;
            end else begin
              instruction_out <= imem_rdata;
              pc_out          <= pc;
              sum_out         <= pc_plus4;
              fetch_valid     <= 1'b1;
              pc              <= pc_plus4;
            end
          end else if (!stall) begin
            instruction_out <= '0;
            pc_out          <= '0;
            sum_out         <= '0;
            fetch_valid     <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instruction_out <= skid_instr;
            pc_out          <= skid_pc;
            sum_out         <= skid_pc + 32'd4;
            fetch_valid     <= 1'b1;
            pc              <= pc_plus4;
            state           <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Outputs were zeroed by the redirect; the drained data is dropped.
          if (imem_ready) begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
